// File: rtl/fetch_decode_queue.sv
// In-order fetch-to-decode instruction queue with valid/ready on both sides.
// Entries carry pc, pc+4, instruction word and a misalignment flag; flush empties it.
module fetch_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_valid,
  output logic                   fetch_ready,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic [XLEN-1:0]        fetch_instr,
  input  logic                   flush,
  output logic                   decode_valid,
  input  logic                   decode_ready,
  output logic [XLEN-1:0]        decode_pc,
  output logic [XLEN-1:0]        decode_pc4,
  output logic [XLEN-1:0]        decode_instr,
  output logic                   decode_misaligned,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            mis;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  entry_t        wr_entry, head;

  assign fetch_ready  = (count_q != CW'(DEPTH));
  assign decode_valid = (count_q != '0);
  assign push = fetch_valid && fetch_ready && !flush;
  assign pop  = decode_valid && decode_ready && !flush;

  assign wr_entry.pc    = fetch_pc;
  assign wr_entry.pc4   = fetch_pc + XLEN'(4);
  assign wr_entry.instr = fetch_instr;
  assign wr_entry.mis   = (fetch_pc[1:0] != 2'b00);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset and flush both collapse the pointers; storage is left as-is.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head data is forced to zero when empty so stale storage never leaks out.
  assign head              = mem_q[rd_ptr_q];
  assign decode_pc         = decode_valid ? head.pc    : '0;
  assign decode_pc4        = decode_valid ? head.pc4   : '0;
  assign decode_instr      = decode_valid ? head.instr : '0;
  assign decode_misaligned = decode_valid ? head.mis   : 1'b0;
  assign count             = count_q;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4, XLEN=32).
module tb_fetch_decode_queue;
  logic        clk = 1'b0;
  logic        reset, fetch_valid, fetch_ready, flush, decode_valid, decode_ready;
  logic [31:0] fetch_pc, fetch_instr, decode_pc, decode_pc4, decode_instr;
  logic        decode_misaligned;
  logic [2:0]  count;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_decode_queue #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .fetch_pc(fetch_pc), .fetch_instr(fetch_instr), .flush(flush),
    .decode_valid(decode_valid), .decode_ready(decode_ready), .decode_pc(decode_pc),
    .decode_pc4(decode_pc4), .decode_instr(decode_instr),
    .decode_misaligned(decode_misaligned), .count(count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; fetch_valid = 0; fetch_pc = '0; fetch_instr = '0; flush = 0; decode_ready = 0;
    cyc(); cyc();
    reset = 0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dvalid", 64'(decode_valid), 64'd0);
    chk("rst_fready", 64'(fetch_ready), 64'd1);
    chk("rst_dpc", 64'(decode_pc), 64'd0);
    chk("rst_dpc4", 64'(decode_pc4), 64'd0);
    chk("rst_dinstr", 64'(decode_instr), 64'd0);

    // single entry
    fetch_valid = 1; fetch_pc = 32'h10; fetch_instr = 32'h00500093;
    cyc();
    fetch_valid = 0;
    chk("one_dvalid", 64'(decode_valid), 64'd1);
    chk("one_pc", 64'(decode_pc), 64'h10);
    chk("one_pc4", 64'(decode_pc4), 64'h14);
    chk("one_instr", 64'(decode_instr), 64'h00500093);
    chk("one_mis", 64'(decode_misaligned), 64'd0);
    chk("one_count", 64'(count), 64'd1);
    decode_ready = 1;
    cyc();
    decode_ready = 0;
    chk("one_pop_count", 64'(count), 64'd0);
    chk("one_pop_dvalid", 64'(decode_valid), 64'd0);

    // fill and stall
    fetch_valid = 1; fetch_instr = 32'h13;
    fetch_pc = 32'h0; cyc();
    fetch_pc = 32'h4; cyc();
    fetch_pc = 32'h8; cyc();
    fetch_pc = 32'hC; cyc();
    chk("full_count", 64'(count), 64'd4);
    chk("full_fready", 64'(fetch_ready), 64'd0);
    fetch_pc = 32'h10; cyc();
    chk("full_nopush_count", 64'(count), 64'd4);
    chk("full_stall_head", 64'(decode_pc), 64'h0);
    // pop with a push attempted while still full
    decode_ready = 1;
    cyc();
    fetch_valid = 0;
    chk("drain1_count", 64'(count), 64'd3);
    chk("drain1_fready", 64'(fetch_ready), 64'd1);
    chk("drain1_head", 64'(decode_pc), 64'h4);
    cyc();
    chk("drain2_head", 64'(decode_pc), 64'h8);
    cyc();
    chk("drain3_head", 64'(decode_pc), 64'hC);
    cyc();
    chk("drain_empty", 64'(count), 64'd0);
    decode_ready = 0;

    // streaming across pointer wrap
    decode_ready = 1; fetch_valid = 1;
    for (int i = 0; i < 12; i++) begin
      fetch_pc = 32'h100 + 32'(4 * i);
      cyc();
      chk("stream_count", 64'(count), 64'd1);
      chk("stream_head", 64'(decode_pc), 64'(32'h100 + 32'(4 * i)));
    end
    fetch_valid = 0;
    cyc();
    chk("stream_end_count", 64'(count), 64'd0);
    decode_ready = 0;

    // flush has priority over push and pop
    fetch_valid = 1;
    fetch_pc = 32'h200; cyc();
    fetch_pc = 32'h204; cyc();
    fetch_pc = 32'h208; cyc();
    chk("pre_flush_count", 64'(count), 64'd3);
    fetch_pc = 32'h20C; flush = 1; decode_ready = 1;
    cyc();
    flush = 0; decode_ready = 0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_dvalid", 64'(decode_valid), 64'd0);
    chk("flush_fready", 64'(fetch_ready), 64'd1);
    fetch_pc = 32'h100;
    cyc();
    fetch_valid = 0;
    chk("post_flush_head", 64'(decode_pc), 64'h100);
    chk("post_flush_count", 64'(count), 64'd1);

    // reset mid-stream, then immediate push
    fetch_valid = 1; fetch_pc = 32'h300; reset = 1;
    cyc();
    reset = 0;
    chk("rst_mid_count", 64'(count), 64'd0);
    fetch_pc = 32'h304;
    cyc();
    fetch_valid = 0;
    chk("rst_mid_head", 64'(decode_pc), 64'h304);
    decode_ready = 1; cyc(); decode_ready = 0;

    // edge data: wraparound pc4 and alignment flag
    fetch_valid = 1;
    fetch_pc = 32'hFFFFFFFC; cyc();
    fetch_pc = 32'h6; cyc();
    fetch_pc = 32'h8; cyc();
    fetch_valid = 0;
    chk("wrap_pc", 64'(decode_pc), 64'hFFFFFFFC);
    chk("wrap_pc4", 64'(decode_pc4), 64'h0);
    chk("wrap_mis", 64'(decode_misaligned), 64'd0);
    decode_ready = 1; cyc();
    chk("mis6_pc4", 64'(decode_pc4), 64'hA);
    chk("mis6_flag", 64'(decode_misaligned), 64'd1);
    cyc();
    chk("al8_pc4", 64'(decode_pc4), 64'hC);
    chk("al8_flag", 64'(decode_misaligned), 64'd0);
    cyc();
    decode_ready = 0;
    chk("edge_end_count", 64'(count), 64'd0);
    chk("edge_end_mis", 64'(decode_misaligned), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

In-order instruction queue between the fetch stage and the decode stage of the RV32I pipeline. Each entry captures the fetched PC, the instruction word, the precomputed PC+4 and an alignment flag. A valid/ready handshake on both sides decouples fetch from decode stalls. A single-cycle flush empties the queue when the pipeline redirects (jump or branch).

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- XLEN, 32, PC and instruction width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch presents an entry this cycle
- fetch_ready  out  1  queue accepts an entry this cycle
- fetch_pc  in  XLEN  PC of the presented instruction
- fetch_instr  in  XLEN  instruction word read from instruction memory
- flush  in  1  discard all entries (pipeline redirect)
- decode_valid  out  1  head entry is available to decode
- decode_ready  in  1  decode consumes the head entry this cycle
- decode_pc  out  XLEN  PC of the head entry
- decode_pc4  out  XLEN  head PC + 4
- decode_instr  out  XLEN  instruction word of the head entry
- decode_misaligned  out  1  head PC[1:0] != 0
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage is DEPTH entries of {pc, pc4, instr, misaligned}.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - Occupancy is tracked in a separate count register.
- Push: occurs when fetch_valid && fetch_ready && !flush.
  - Writes entry[wr_ptr] and increments wr_ptr.
  - pc4 is fetch_pc + 4, computed modulo 2^XLEN: 0xFFFFFFFC gives 0x00000000.
  - misaligned is (fetch_pc[1:0] != 0).
- Pop: occurs when decode_valid && decode_ready && !flush. Increments rd_ptr.
- Count update:
  - push only: +1
  - pop only: -1
  - both, or neither: unchanged
- fetch_ready = (count != DEPTH).
  - It has no combinational dependence on decode_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
- decode_valid = (count != 0).
- Head outputs show entry[rd_ptr] when decode_valid=1. When decode_valid=0, decode_pc, decode_pc4, decode_instr and decode_misaligned are all 0.
- Flush:
  - Sets wr_ptr, rd_ptr and count to 0 at the next edge.
  - Has priority over a push and a pop in the same cycle; both are dropped.
  - Storage contents are not cleared.
- Reset has the same effect as flush and takes priority over it.
- Entries leave in the order they entered.
- No state machine beyond the pointer and count registers. States are defined by count:
  - EMPTY: count = 0
  - PARTIAL: 0 < count < DEPTH
  - FULL: count = DEPTH

## Timing
- Reset values, from the edge where reset=1 is sampled:
  - count = 0
  - decode_valid = 0
  - fetch_ready = 1
  - all decode data outputs = 0
- Latency: an entry pushed at edge N is visible on decode_* after edge N. An entry is never passed from fetch_* to decode_* in the same cycle.
- Throughput: one push and one pop per cycle are sustained when 0 < count < DEPTH.
- Full, with pop and attempted push in the same cycle: the pop happens and count drops to DEPTH-1. fetch_ready rises in the next cycle.
- Empty, with push and decode_ready=1 in the same cycle: the push happens, no pop occurs, and count becomes 1.
- Flush while fetch_valid=1: the presented entry is dropped. Fetch must re-present it with the redirected PC.
- Reset or flush asserted mid-stream: the queue is empty in the following cycle, and pushes resume in that same cycle.
- decode_* outputs must stay stable while decode_valid=1 and decode_ready=0.

## Test plan
- Reset sequence: hold reset for 2 cycles, then release. Required: count=0, decode_valid=0, fetch_ready=1, decode_pc=0.
- Single entry: push pc=0x00000010, instr=0x00500093. One cycle later: decode_valid=1, decode_pc=0x10, decode_pc4=0x14, decode_instr=0x00500093. Pop it; count returns to 0.
- Fill and stall: with decode_ready=0, push pc=0x0, 0x4, 0x8, 0xC.
  - Required: count=4, fetch_ready=0, and a fifth push is not accepted.
  - Then raise decode_ready: entries pop in order 0x0, 0x4, 0x8, 0xC, and fetch_ready returns 1 the cycle after the first pop.
- Streaming with wrap: push and pop every cycle for 12 instructions. Required:
  - count stays at 1 after the first cycle;
  - PCs come out in order;
  - pointers wrap with no lost or duplicated entry.
- Flush priority: with count=3, assert flush together with fetch_valid=1 and decode_ready=1. Next cycle: count=0, decode_valid=0. A push of pc=0x00000100 in the following cycle appears at the head.
- Edge data cases:
  - pc=0xFFFFFFFC yields decode_pc4=0x00000000.
  - pc=0x00000006 yields decode_misaligned=1.
  - pc=0x00000008 yields decode_misaligned=0.
